// File: rtl/sm83_bus_monitor.sv
`timescale 1ns/1ps
// sm83_bus_monitor: passive SM83 bus observer that logs every read/write access into a show-ahead record FIFO.
// Define SM83_BUSMON_TIMESTAMP_EN to stamp each record with a 16-bit cycle count and expose it on rec_ts.
module sm83_bus_monitor #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                CLK,
  input  logic                nRESET,
  input  logic                MREQ,
  input  logic                RD,
  input  logic                WR,
  input  logic [15:0]         A,
  input  logic [7:0]          D,
  output logic                rec_valid,
  input  logic                rec_ready,
  output logic [15:0]         rec_addr,
  output logic [7:0]          rec_data,
  output logic                rec_we,
`ifdef SM83_BUSMON_TIMESTAMP_EN
  output logic [15:0]         rec_ts,
`endif
  output logic [DEPTH_LOG2:0] level,
  output logic                overflow,
  input  logic                clr_ovf,
  output logic [15:0]         txn_count
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
`ifdef SM83_BUSMON_TIMESTAMP_EN
  localparam int REC_W = 41;
`else
  localparam int REC_W = 25;
`endif

  typedef enum logic [1:0] {IDLE, RD_ACT, WR_ACT} state_t;
  state_t state, next_state;

  logic                  s_mreq, s_rd, s_wr;
  logic [15:0]           s_a;
  logic [7:0]            s_d;
  logic                  rdq, wrq;
  logic                  close_rec, open_rec, cur_we;
  logic [15:0]           cur_addr;
  logic [7:0]            cur_data;
  logic [REC_W-1:0]      push_rec, head;
  logic [REC_W-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_ptr, wr_ptr, rd_nxt;
  logic                  pop_fire, push_ok, drop;

  // Input stage: raw bus sampled every edge; nothing downstream looks at the raw pins
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      s_mreq <= 1'b0;
      s_rd   <= 1'b0;
      s_wr   <= 1'b0;
      s_a    <= '0;
      s_d    <= '0;
    end else begin
      s_mreq <= MREQ;
      s_rd   <= RD;
      s_wr   <= WR;
      s_a    <= A;
      s_d    <= D;
    end
  end

  assign rdq = s_mreq & s_rd & ~s_wr;
  assign wrq = s_mreq & s_wr;

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) state <= IDLE;
    else         state <= next_state;
  end

  // rdq and wrq are exclusive, so the decoded access alone picks the next state
  always_comb begin
    next_state = IDLE;
    if (wrq)      next_state = WR_ACT;
    else if (rdq) next_state = RD_ACT;
  end

  always_comb begin
    close_rec = 1'b0;
    open_rec  = 1'b0;
    if (state == IDLE) begin
      open_rec = (next_state != IDLE);
    end else begin
      close_rec = (next_state != state) || (s_a != cur_addr);
      open_rec  = (next_state != IDLE) && close_rec;
    end
  end

  assign cur_we = (state == WR_ACT);

  // Transaction stage: open record tracks the last active data beat
  always_ff @(posedge CLK) begin
    if (open_rec)           cur_addr <= s_a;
    if (next_state != IDLE) cur_data <= s_d;
  end

`ifdef SM83_BUSMON_TIMESTAMP_EN
  logic [15:0] ts_cnt, cur_ts;

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) ts_cnt <= '0;
    else         ts_cnt <= ts_cnt + 16'd1;
  end

  always_ff @(posedge CLK) begin
    if (open_rec) cur_ts <= ts_cnt;
  end

  assign push_rec = {cur_ts, cur_addr, cur_data, cur_we};
  assign rec_ts   = head[40:25];
`else
  assign push_rec = {cur_addr, cur_data, cur_we};
`endif

  assign rec_addr = head[24:9];
  assign rec_data = head[8:1];
  assign rec_we   = head[0];

  // FIFO stage: head register mirrors mem[rd_ptr] and holds its value once drained
  assign rec_valid = (level != '0);
  assign pop_fire  = rec_valid & rec_ready;
  assign push_ok   = close_rec & ((level != LVL_FULL) | pop_fire);
  assign drop      = close_rec & ~push_ok;
  assign rd_nxt    = rd_ptr + PTR_ONE;

  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr] <= push_rec;
  end

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      level     <= '0;
      head      <= '0;
      overflow  <= 1'b0;
      txn_count <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_fire) begin
        rd_ptr <= rd_nxt;
        if (level > LVL_ONE) head <= mem[rd_nxt];
        else if (push_ok)    head <= push_rec;
      end else if (push_ok && !rec_valid) begin
        head <= push_rec;
      end
      case ({push_ok, pop_fire})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
      if (drop)         overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
      if (close_rec) txn_count <= txn_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_sm83_bus_monitor.sv
`timescale 1ns/1ps
// tb_sm83_bus_monitor: directed and randomized bus traffic against a run-based transaction model of the monitor.
module tb_sm83_bus_monitor;
  localparam int DEPTH = 16;

  logic        CLK = 1'b0;
  logic        nRESET = 1'b0;
  logic        MREQ, RD, WR;
  logic [15:0] A;
  logic [7:0]  D;
  logic        rec_valid, rec_ready, rec_we, overflow, clr_ovf;
  logic [15:0] rec_addr, txn_count;
  logic [7:0]  rec_data;
  logic [4:0]  level;
`ifdef SM83_BUSMON_TIMESTAMP_EN
  logic [15:0] rec_ts;
`endif

  sm83_bus_monitor #(.DEPTH_LOG2(4)) dut (
    .CLK(CLK), .nRESET(nRESET), .MREQ(MREQ), .RD(RD), .WR(WR), .A(A), .D(D),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_addr(rec_addr),
    .rec_data(rec_data), .rec_we(rec_we),
`ifdef SM83_BUSMON_TIMESTAMP_EN
    .rec_ts(rec_ts),
`endif
    .level(level), .overflow(overflow), .clr_ovf(clr_ovf), .txn_count(txn_count)
  );

  always #5 CLK = ~CLK;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
    logic        we;
    logic [15:0] ts;
  } rec_t;

  rec_t        q[$];
  rec_t        shown;
  logic        sm, sr, sw;
  logic [15:0] sa;
  logic [7:0]  sd;
  logic        run_open, run_we, m_ovf;
  logic [15:0] run_a, run_ts, m_ts, m_txn;
  logic [7:0]  run_d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    shown    = '0;
    {sm, sr, sw} = 3'b000;
    sa       = '0;
    sd       = '0;
    run_open = 1'b0;
    run_we   = 1'b0;
    run_a    = '0;
    run_d    = '0;
    run_ts   = '0;
    m_ts     = '0;
    m_txn    = '0;
    m_ovf    = 1'b0;
  endtask

  task automatic check_all();
    chk("valid", 32'(rec_valid), 32'(q.size() > 0));
    chk("level", 32'(level), 32'(q.size()));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("txn_count", 32'(txn_count), 32'(m_txn));
    chk("rec_addr", 32'(rec_addr), 32'(shown.a));
    chk("rec_data", 32'(rec_data), 32'(shown.d));
    chk("rec_we", 32'(rec_we), 32'(shown.we));
`ifdef SM83_BUSMON_TIMESTAMP_EN
    chk("rec_ts", 32'(rec_ts), 32'(shown.ts));
`endif
  endtask

  // One clock edge: a run of identical decoded accesses is one record, emitted one edge after it ends
  task automatic tick();
    int   ks;
    logic closing, pop, dropped;
    rec_t r;
    @(posedge CLK);
    ks      = (sm && sw) ? 2 : ((sm && sr) ? 1 : 0);
    closing = run_open && ((ks != (run_we ? 2 : 1)) || (sa != run_a));
    pop     = (q.size() > 0) && rec_ready;
    dropped = 1'b0;
    if (pop) void'(q.pop_front());
    if (closing) begin
      m_txn = m_txn + 16'd1;
      r.a = run_a; r.d = run_d; r.we = run_we; r.ts = run_ts;
      if (q.size() < DEPTH) q.push_back(r);
      else dropped = 1'b1;
    end
    if (dropped)      m_ovf = 1'b1;
    else if (clr_ovf) m_ovf = 1'b0;
    if (ks != 0) begin
      if (!run_open || closing) begin
        run_open = 1'b1;
        run_we   = (ks == 2);
        run_a    = sa;
        run_ts   = m_ts;
      end
      run_d = sd;
    end else begin
      run_open = 1'b0;
    end
    m_ts = m_ts + 16'd1;
    sm = MREQ; sr = RD; sw = WR; sa = A; sd = D;
    if (q.size() > 0) shown = q[0];
    #1 check_all();
  endtask

  task automatic bus(input logic m, input logic r, input logic w,
                     input logic [15:0] a, input logic [7:0] d);
    MREQ = m; RD = r; WR = w; A = a; D = d;
  endtask

  task automatic expect_head(input string tag, input logic [15:0] a,
                             input logic [7:0] d, input logic we);
    chk({tag, "_valid"}, 32'(rec_valid), 32'd1);
    chk({tag, "_addr"}, 32'(rec_addr), 32'(a));
    chk({tag, "_data"}, 32'(rec_data), 32'(d));
    chk({tag, "_we"}, 32'(rec_we), 32'(we));
  endtask

  task automatic pop1();
    rec_ready = 1'b1;
    tick();
    rec_ready = 1'b0;
  endtask

  // Called 1 time unit after a rising edge; asserts reset mid-cycle and releases it after one edge
  task automatic do_reset();
    #2 nRESET = 1'b0;
    #1 model_reset();
    chk("rst_valid", 32'(rec_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_txn", 32'(txn_count), 32'd0);
    chk("rst_addr", 32'(rec_addr), 32'd0);
    chk("rst_data", 32'(rec_data), 32'd0);
    chk("rst_we", 32'(rec_we), 32'd0);
    @(posedge CLK);
    #1 check_all();
    #3 nRESET = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          kind, hold;
    logic [15:0] ra;
    bit          slow;
    bus(0, 0, 0, 16'h0000, 8'h00);
    rec_ready = 1'b0;
    clr_ovf   = 1'b0;
    model_reset();
    #1;
    chk("init_valid", 32'(rec_valid), 32'd0);
    chk("init_level", 32'(level), 32'd0);
    chk("init_txn", 32'(txn_count), 32'd0);
    check_all();
    #13 nRESET = 1'b1;

    // Read of 0x0100 / 0x3E held three cycles, consumer always ready
    rec_ready = 1'b1;
    bus(1, 1, 0, 16'h0100, 8'h3E);
    repeat (3) tick();
    bus(0, 0, 0, 16'h0000, 8'h00);
    tick();
    chk("t1_valid_early", 32'(rec_valid), 32'd0);
    tick();
    expect_head("t1", 16'h0100, 8'h3E, 1'b0);
    chk("t1_txn", 32'(txn_count), 32'd1);
    tick();
    chk("t1_drained", 32'(level), 32'd0);
    rec_ready = 1'b0;

    // Write then read of 0xC000 with MREQ held across both
    bus(1, 0, 1, 16'hC000, 8'h55);
    repeat (2) tick();
    bus(1, 1, 0, 16'hC000, 8'h77);
    repeat (2) tick();
    bus(0, 0, 0, 16'h0000, 8'h00);
    repeat (2) tick();
    chk("t2_level", 32'(level), 32'd2);
    expect_head("t2_wr", 16'hC000, 8'h55, 1'b1);
    pop1();
    expect_head("t2_rd", 16'hC000, 8'h77, 1'b0);
    pop1();

    // Address step during a held read
    bus(1, 1, 0, 16'h0200, 8'h11);
    repeat (2) tick();
    bus(1, 1, 0, 16'h0201, 8'h22);
    repeat (2) tick();
    bus(0, 0, 0, 16'h0000, 8'h00);
    repeat (2) tick();
    expect_head("t3_a", 16'h0200, 8'h11, 1'b0);
    pop1();
    expect_head("t3_b", 16'h0201, 8'h22, 1'b0);
    pop1();

    // Seventeen single-cycle reads into a stalled FIFO
    do_reset();
    for (int i = 0; i < 17; i++) begin
      bus(1, 1, 0, 16'(i), 8'(i + 16));
      tick();
    end
    bus(0, 0, 0, 16'h0000, 8'h00);
    repeat (2) tick();
    chk("t4_level", 32'(level), 32'd16);
    chk("t4_ovf", 32'(overflow), 32'd1);
    chk("t4_txn", 32'(txn_count), 32'd17);
    for (int i = 0; i < 16; i++) begin
      expect_head("t4_drain", 16'(i), 8'(i + 16), 1'b0);
      pop1();
    end
    chk("t4_empty", 32'(level), 32'd0);
    chk("t4_ovf_held", 32'(overflow), 32'd1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("t4_ovf_clr", 32'(overflow), 32'd0);

    // Full FIFO with a simultaneous pop as a new access closes
    do_reset();
    for (int i = 0; i < 16; i++) begin
      bus(1, 1, 0, 16'h0300 + 16'(i), 8'h40 + 8'(i));
      tick();
    end
    bus(1, 1, 0, 16'h0BEE, 8'h5A);
    repeat (2) tick();
    chk("t5_full", 32'(level), 32'd16);
    bus(0, 0, 0, 16'h0000, 8'h00);
    tick();
    pop1();
    chk("t5_level", 32'(level), 32'd16);
    chk("t5_ovf", 32'(overflow), 32'd0);
    chk("t5_txn", 32'(txn_count), 32'd17);
    for (int i = 1; i < 16; i++) begin
      expect_head("t5_drain", 16'h0300 + 16'(i), 8'h40 + 8'(i), 1'b0);
      pop1();
    end
    expect_head("t5_last", 16'h0BEE, 8'h5A, 1'b0);
    pop1();

    // Reset pulse in the middle of a write, then a read of 0x1234 / 0xAA
    bus(1, 0, 1, 16'h5000, 8'h99);
    repeat (3) tick();
    bus(1, 1, 0, 16'h1234, 8'hAA);
    do_reset();
    tick();
    bus(0, 0, 0, 16'h0000, 8'h00);
    repeat (2) tick();
    chk("t6_level", 32'(level), 32'd1);
    chk("t6_txn", 32'(txn_count), 32'd1);
    expect_head("t6", 16'h1234, 8'hAA, 1'b0);
    pop1();

    // Randomized bursts with slow-consumer phases to exercise the full boundary
    for (int b = 0; b < 700; b++) begin
      kind = $urandom_range(0, 6);
      hold = $urandom_range(1, 3);
      ra   = 16'h4000 + 16'($urandom_range(0, 3));
      slow = ((b / 100) % 2) == 1;
      case (kind)
        0: bus(0, 0, 0, ra, 8'h00);
        1: bus(1, 1, 0, ra, 8'h00);
        2: bus(1, 0, 1, ra, 8'h00);
        3: bus(1, 1, 1, ra, 8'h00);
        4: bus(1, 0, 0, ra, 8'h00);
        5: bus(0, 1, 0, ra, 8'h00);
        default: bus(0, 0, 1, ra, 8'h00);
      endcase
      for (int h = 0; h < hold; h++) begin
        D         = 8'($urandom);
        rec_ready = slow ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
        clr_ovf   = ($urandom_range(0, 15) == 0);
        tick();
      end
    end
    clr_ovf = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
